spi_flash_rd_ctrl: RTL and testbench

Read sequencer that sits between the CPU instruction/data fetch path and the external SPI NOR flash (N25Q-class) pins of `soc_top`. It accepts one 32-bit read request at a time, drives a complete SPI mode-0 READ transaction (command, 24-bit address, 32 data bits) on the `spi_cs`/`spi_clk`/`spi_mosi`/`spi_miso` pins, and returns the assembled word. It runs entirely in the `clk` domain with a programmable SCK divider.

---
 rtl/spi_flash_rd_ctrl.sv | 153 +++++++++++++++
 tb/tb_spi_flash_rd_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_rd_ctrl.sv
// SPI NOR flash read sequencer: one 32-bit mode-0 READ per request.
// Optional fast read (0x0B + 8 dummy clocks) via SPI_FLASH_FAST_READ_EN.
module spi_flash_rd_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [24:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, GAP
  } state_t;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, GAP
  } state_t;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic [31:0] tx;
  logic [31:0] rx;
  logic        busy;
  logic        div_last;
  logic        sck_rise;
  logic        bit_end;
  logic        bit_last;
  logic        hs;

  assign hs       = req_valid && req_ready;
`ifdef SPI_FLASH_FAST_READ_EN
  assign busy     = state inside {CMD, ADDR, DUMMY, DATA};
`else
  assign busy     = state inside {CMD, ADDR, DATA};
`endif
  assign div_last = div_cnt == DIV_LAST;
  assign sck_rise = busy && !spi_clk && div_last;
  assign bit_end  = busy && spi_clk && div_last;

  // Next state; a phase ends on the high-phase end of its last bit.
  always_comb begin
    state_nxt = state;
    bit_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) state_nxt = CMD;
      end
      CMD: begin
        bit_last = bit_cnt == 5'd7;
        if (bit_end && bit_last) state_nxt = ADDR;
      end
      ADDR: begin
        bit_last = bit_cnt == 5'd23;
`ifdef SPI_FLASH_FAST_READ_EN
        if (bit_end && bit_last) state_nxt = DUMMY;
`else
        if (bit_end && bit_last) state_nxt = DATA;
`endif
      end
`ifdef SPI_FLASH_FAST_READ_EN
      DUMMY: begin
        bit_last = bit_cnt == 5'd7;
        if (bit_end && bit_last) state_nxt = DATA;
      end
`endif
      DATA: begin
        bit_last = bit_cnt == 5'd31;
        if (bit_end && bit_last) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // SCK timing, shift registers and registered pin/response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      spi_cs    <= 2'b11;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
    end else begin
      req_ready <= state_nxt == IDLE;
      rsp_valid <= 1'b0;
      if (hs) begin
        spi_cs   <= req_addr[24] ? 2'b01 : 2'b10;
        spi_mosi <= OPCODE[7];
        tx       <= {OPCODE[6:0], req_addr[23:0], 1'b0};
        spi_clk  <= 1'b0;
        div_cnt  <= '0;
        bit_cnt  <= '0;
      end else if (busy) begin
        if (div_last) begin
          div_cnt <= '0;
          spi_clk <= ~spi_clk;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (sck_rise && state == DATA)
          rx <= {rx[30:0], spi_miso};
        if (bit_end) begin
          spi_mosi <= tx[31];
          tx       <= {tx[30:0], 1'b0};
          bit_cnt  <= bit_last ? 5'd0 : bit_cnt + 5'd1;
          if (state == DATA && bit_last) begin
            spi_cs    <= 2'b11;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= {rx[7:0], rx[15:8],
                          rx[23:16], rx[31:24]};
          end
        end
      end
      if (state == GAP) gap_cnt <= gap_cnt + 4'd1;
      else              gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Bench for spi_flash_rd_ctrl: flash model, cycle model, random reads.
// Also exercises a CLK_DIV=1 instance for SCK rate and latency.
module tb_spi_flash_rd_ctrl;
  localparam int DIV  = 2;
  localparam int GAPN = 4;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int NBITS    = 72;
  localparam int LAT_PIN  = 289;
  localparam int LAT1_PIN = 145;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int NBITS    = 64;
  localparam int LAT_PIN  = 257;
  localparam int LAT1_PIN = 129;
  localparam logic [7:0] OPC = 8'h03;
`endif
  localparam int HDR = NBITS - 32;
  localparam int LAT = NBITS * 2 * DIV + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [24:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  spi_cs;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  logic        req_valid2;
  logic        req_ready2;
  logic [24:0] req_addr2;
  logic        rsp_valid2;
  logic [31:0] rsp_data2;
  logic [1:0]  spi_cs2;
  logic        spi_clk2;
  logic        spi_mosi2;
  logic        spi_miso2 = 1'b0;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  spi_flash_rd_ctrl #(.CLK_DIV(DIV), .CS_GAP(GAPN)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_flash_rd_ctrl #(.CLK_DIV(1), .CS_GAP(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_addr(req_addr2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .spi_cs(spi_cs2), .spi_clk(spi_clk2),
    .spi_mosi(spi_mosi2), .spi_miso(spi_miso2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mem(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h13;
      24'h000101: return 8'h05;
      24'h000102: return 8'h00;
      24'h000103: return 8'h00;
      default:    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'hA7;
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [23:0] a);
    return {mem(a + 24'd3), mem(a + 24'd2), mem(a + 24'd1), mem(a)};
  endfunction

  // Cycle model: m_n = cycles since handshake (0 = idle).
  int          m_n = 0;
  bit          m_rdy = 1'b0;
  logic [31:0] m_dat = '0;
  logic [31:0] m_next = '0;
  logic [24:0] m_addr = '0;
  int          cyc = 0;
  int          hs_cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_n = 0; m_rdy = 1'b0; m_dat = '0;
    end else begin
      if (m_n == 0) begin
        if (m_rdy && req_valid) begin
          m_n = 1; m_addr = req_addr; hs_cyc = cyc;
          m_next = word(req_addr[23:0]);
        end
      end else if (m_n == LAT + GAPN - 1) begin
        m_n = 0;
      end else begin
        m_n++;
      end
      if (m_n == LAT) m_dat = m_next;
      m_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    bit act;
    int ph, b;
    logic [1:0] ecs;
    logic eclk, emosi;
    if (en) begin
      act  = m_n >= 1 && m_n < LAT;
      ecs  = !act ? 2'b11 : (m_addr[24] ? 2'b01 : 2'b10);
      ph   = (m_n - 1) % (2 * DIV);
      b    = (m_n - 1) / (2 * DIV);
      eclk = act && ph >= DIV;
      emosi = 1'b0;
      if (act && b < 8) emosi = OPC[3'(7 - b)];
      else if (act && b < 32) emosi = m_addr[5'(31 - b)];
      chk("ready", req_ready, 32'(m_n == 0 && m_rdy));
      chk("cs", spi_cs, ecs);
      chk("sck", spi_clk, eclk);
      chk("mosi", spi_mosi, emosi);
      chk("rsp_valid", rsp_valid, 32'(m_n == LAT));
      chk("rsp_data", rsp_data, m_dat);
    end
  end

  // Flash: captures command/address on SCK rise, serves bytes from mem.
  int          rises = 0;
  bit          prev_sck = 1'b0;
  logic [31:0] hdr_sr = '0;
  logic [23:0] faddr = '0;

  always @(negedge clk) begin : flash
    int d;
    logic [7:0] byt;
    if (spi_cs === 2'b11 || !rst_n) begin
      rises = 0; prev_sck = 1'b0; spi_miso = 1'b0;
    end else begin
      if (spi_clk && !prev_sck) begin
        if (rises < 32) hdr_sr = {hdr_sr[30:0], spi_mosi};
        rises++;
        if (rises == 32) begin
          chk("flash_op", hdr_sr[31:24], OPC);
          chk("flash_addr", hdr_sr[23:0], m_addr[23:0]);
          faddr = hdr_sr[23:0];
        end
      end
      prev_sck = spi_clk;
      if (rises >= HDR) begin
        d = rises - HDR;
        byt = mem(faddr + 24'(d / 8));
        spi_miso = byt[3'(7 - d % 8)];
      end else begin
        spi_miso = 1'($urandom);
      end
    end
  end

  // CLK_DIV=1 instance monitor; flash returns alternating bits.
  bit act2 = 1'b0, d1_done = 1'b0, prevc2 = 1'b0;
  int lat2 = 0, rises2 = 0, togs2 = 0, csbad2 = 0;

  always @(negedge clk) begin : mon2
    if (!en) begin
      spi_miso2 = 1'b0;
    end else if (req_valid2 && req_ready2) begin
      act2 = 1'b1; lat2 = 0; rises2 = 0;
      togs2 = 0; csbad2 = 0; prevc2 = 1'b0;
    end else if (act2) begin
      lat2++;
      if (spi_clk2 !== prevc2) togs2++;
      if (spi_clk2 && !prevc2) rises2++;
      prevc2 = spi_clk2;
      if (lat2 < LAT1_PIN && spi_cs2 !== 2'b10) csbad2++;
      if (lat2 == 1) chk("d1_mosi_first", spi_mosi2, OPC[7]);
      spi_miso2 = rises2[0];
      if (rsp_valid2 || lat2 > 300) begin
        chk("d1_rsp_seen", rsp_valid2, 1);
        chk("d1_latency", lat2, LAT1_PIN);
        chk("d1_rises", rises2, NBITS);
        chk("d1_toggles", togs2, 2 * NBITS);
        chk("d1_cs_bad", csbad2, 0);
        chk("d1_data", rsp_data2, 32'h55555555);
        act2 = 1'b0; d1_done = 1'b1;
      end
    end
  end

  task automatic do_req(input logic [24:0] a, input bit keep);
    int w = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (req_ready !== 1'b1 && w < 2000) begin
      @(negedge clk); w++;
    end
    chk("hs_ready", req_ready, 1);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int w = 0;
    while (rsp_valid !== 1'b1 && w < 1000) begin
      @(negedge clk); w++;
    end
    chk("rsp_seen", rsp_valid, 1);
    lat = cyc - hs_cyc + 1;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (req_ready !== 1'b1 && w < 1000) begin
      @(negedge clk); w++;
    end
    chk("idle", req_ready, 1);
  endtask

  initial begin
    int lat, w;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
    req_valid2 = 1'b0; req_addr2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    chk("rst_ready", req_ready, 0);
    chk("rst_cs", spi_cs, 2'b11);
    chk("rst_sck", spi_clk, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    do_req(25'h0000100, 1'b0);
    chk("first_cs", spi_cs, 2'b10);
    chk("first_mosi", spi_mosi, OPC[7]);
    chk("first_sck", spi_clk, 0);
    wait_rsp(lat);
    chk("first_data", rsp_data, 32'h00000513);
    chk("first_latency", lat, LAT_PIN);
    wait_idle();

    do_req(25'h1FFFFFC, 1'b0);
    chk("sel1_cs", spi_cs, 2'b01);
    wait_idle();

    do_req(25'h0ABCDEF, 1'b1);
    do_req(25'h1123456, 1'b1);
    do_req(25'h0FFFFFF, 1'b0);
    wait_idle();

    repeat (14) begin
      do_req(25'($urandom), 1'($urandom));
      if (!req_valid) repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    req_valid = 1'b0;
    wait_idle();

    do_req(25'($urandom), 1'b0);
    w = 0;
    while (m_n != 1 + (HDR + 10) * 2 * DIV && w < 1000) begin
      @(negedge clk); w++;
    end
    chk("reached_bit10", m_n, 1 + (HDR + 10) * 2 * DIV);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_cs", spi_cs, 2'b11);
    chk("midrst_sck", spi_clk, 0);
    chk("midrst_rsp", rsp_valid, 0);
    wait_idle();
    do_req(25'h0000100, 1'b0);
    wait_rsp(lat);
    chk("post_rst_data", rsp_data, 32'h00000513);
    wait_idle();

    req_valid2 = 1'b1;
    req_addr2  = 25'h0123456;
    w = 0;
    while (req_ready2 !== 1'b1 && w < 100) begin
      @(negedge clk); w++;
    end
    @(negedge clk);
    req_valid2 = 1'b0;
    w = 0;
    while (!d1_done && w < 500) begin
      @(negedge clk); w++;
    end
    chk("d1_done", 32'(d1_done), 1);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
